// File: rtl/inst_fetch_bus_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : inst_fetch_bus_ctrl_pkg
//  Description : Shared types and constants for the instruction-fetch bus
//                controller: FSM state encoding, bus word-size constant and
//                the in-flight tracking entry.
//  Revision    : 1.0 - initial release
// ============================================================================
package inst_fetch_bus_ctrl_pkg;

  // Bus-side sequencer state. IDLE: no request on the bus. REQ: inst_req held.
  typedef enum logic [0:0] {
    IDLE = 1'b0,
    REQ  = 1'b1
  } fetch_state_e;

  // inst_size encoding for a 32-bit word transfer.
  localparam logic [1:0] c_INST_SIZE_WORD = 2'b10;

  // One in-flight fetch.
  //   nobus   : completes locally (exception entry), never waits on inst_data_ok
  //   discard : response must not be forwarded to the second stage
  typedef struct packed {
    logic nobus;
    logic discard;
  } track_entry_t;

endpackage : inst_fetch_bus_ctrl_pkg
`default_nettype wire

// File: rtl/inst_fetch_bus_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module      : inst_fetch_bus_ctrl_if
//  Description : Instruction-side SRAM-like bus bundle.
//                master modport : fetch controller (drives request/address)
//                slave  modport : bus / memory side (drives handshakes)
//  Ports       : inst_req, inst_wr, inst_size, inst_addr (master -> slave)
//                inst_addr_ok, inst_data_ok               (slave -> master)
//  Revision    : 1.0 - initial release
// ============================================================================
interface inst_fetch_bus_ctrl_if #(
  parameter int ADDR_W = 32
);

  logic              inst_req;
  logic              inst_wr;
  logic [1:0]        inst_size;
  logic [ADDR_W-1:0] inst_addr;
  logic              inst_addr_ok;
  logic              inst_data_ok;

  modport master (
    output inst_req,
    output inst_wr,
    output inst_size,
    output inst_addr,
    input  inst_addr_ok,
    input  inst_data_ok
  );

  modport slave (
    input  inst_req,
    input  inst_wr,
    input  inst_size,
    input  inst_addr,
    output inst_addr_ok,
    output inst_data_ok
  );

endinterface : inst_fetch_bus_ctrl_if
`default_nettype wire

// File: rtl/inst_fetch_bus_ctrl_fetch_track_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : fetch_track_fifo
//  Description : Ordered tracking queue for in-flight fetches. Accepts up to
//                two pushes per cycle (entry a is older than entry b), one pop,
//                and a broadcast that marks every stored entry as discard.
//  Ports       : clk, rst          clock, async active-high reset
//                push_a/data_a     first (older) entry to enqueue
//                push_b/data_b     second entry to enqueue (after a)
//                pop               remove head
//                set_discard       set discard on every stored entry
//                count             number of valid entries
//                head              view of the oldest entry
//  Revision    : 1.0 - initial release
// ============================================================================
module fetch_track_fifo
  import inst_fetch_bus_ctrl_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int CNT_W = $clog2(DEPTH + 1)
) (
  input  wire logic             clk,
  input  wire logic             rst,
  input  wire logic             push_a,
  input  wire track_entry_t     data_a,
  input  wire logic             push_b,
  input  wire track_entry_t     data_b,
  input  wire logic             pop,
  input  wire logic             set_discard,
  output logic [CNT_W-1:0]      count,
  output track_entry_t          head
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  track_entry_t     r_mem [DEPTH];
  logic [PTR_W-1:0] r_rd_ptr;
  logic [PTR_W-1:0] r_wr_ptr;
  logic [CNT_W-1:0] r_count;
  logic [PTR_W-1:0] w_wr_b;
  logic [PTR_W-1:0] w_wr_next;

  // Pointers wrap modulo DEPTH, which need not be a power of two.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    if (p == PTR_W'(DEPTH - 1)) return '0;
    else                        return p + PTR_W'(1);
  endfunction

  // Entry b lands one slot after entry a when both push together.
  assign w_wr_b    = push_a ? ptr_inc(r_wr_ptr) : r_wr_ptr;
  assign w_wr_next = push_b ? ptr_inc(w_wr_b)   : w_wr_b;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else begin
      // Pushed data already carries the same-cycle discard, so a freshly
      // written slot takes its data as-is.
      for (int i = 0; i < DEPTH; i++) begin
        if (push_a && (r_wr_ptr == PTR_W'(i)))    r_mem[i] <= data_a;
        else if (push_b && (w_wr_b == PTR_W'(i))) r_mem[i] <= data_b;
        else if (set_discard)                     r_mem[i].discard <= 1'b1;
      end
      if (pop) r_rd_ptr <= ptr_inc(r_rd_ptr);
      r_wr_ptr <= w_wr_next;
      r_count  <= r_count + CNT_W'(push_a) + CNT_W'(push_b) - CNT_W'(pop);
    end
  end

  assign count = r_count;
  assign head  = r_mem[r_rd_ptr];

endmodule : fetch_track_fifo
`default_nettype wire

// File: rtl/inst_fetch_bus_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : inst_fetch_bus_ctrl
//  Description : Instruction-side bus sequencer for the IF pipeline. Issues
//                fetches on the SRAM-like bus, tracks them in order, drops
//                responses belonging to cancelled fetches and completes
//                exception requests locally without touching the bus.
//  Ports       : clk, rst                 clock, async active-high reset
//                FCT_valid_i/PAddr_i/hasException_i   fetch request
//                BSC/CP0/SBA cancel inputs            ORed into one cancel
//                SCT_allowin_w_i          second stage takes local completion
//                fetch_accept_o           request consumed this cycle
//                bus                      instruction bus (master side)
//                pipe_data_ok_o/pipe_exc_o  live completion / exception flag
//                busy_o                   request on bus or entries in flight
//                err_o                    sticky: data_ok with empty queue
//  Revision    : 1.0 - initial release
// ============================================================================
module inst_fetch_bus_ctrl
  import inst_fetch_bus_ctrl_pkg::*;
#(
  parameter int MAX_OUTSTANDING = 2,
  parameter int ADDR_W          = 32
) (
  input  wire logic              clk,
  input  wire logic              rst,
  input  wire logic              FCT_valid_i,
  input  wire logic [ADDR_W-1:0] FCT_PAddr_i,
  input  wire logic              FCT_hasException_i,
  input  wire logic              BSC_needCancel_w_i,
  input  wire logic              CP0_excOccur_w_i,
  input  wire logic              SBA_flush_w_i,
  input  wire logic              SCT_allowin_w_i,
  output logic                   fetch_accept_o,
  inst_fetch_bus_ctrl_if.master  bus,
  output logic                   pipe_data_ok_o,
  output logic                   pipe_exc_o,
  output logic                   busy_o,
  output logic                   err_o
);

  localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);

  fetch_state_e      r_state;
  fetch_state_e      w_state_next;
  logic [ADDR_W-1:0] r_inst_addr;
  logic              r_cancel_seen;
  logic              r_err;

  logic              w_cancel;
  logic              w_in_req;
  logic              w_free;
  logic              w_accept;
  logic              w_accept_bus;
  logic              w_bus_push;
  logic              w_exc_push;
  logic              w_pop;
  logic [CNT_W-1:0]  w_count;
  track_entry_t      w_head;
  track_entry_t      w_bus_entry;
  track_entry_t      w_exc_entry;
  logic              w_push_a;
  logic              w_push_b;
  track_entry_t      w_data_a;

  assign w_cancel = BSC_needCancel_w_i | CP0_excOccur_w_i | SBA_flush_w_i;
  assign w_in_req = (r_state == REQ);

  // The request currently on the bus occupies a slot.
  assign w_free = (int'(w_count) + (w_in_req ? 1 : 0)) < MAX_OUTSTANDING;

  // A no-bus head only yields to bus data; a bus head pops on data return.
  always_comb begin
    w_pop = 1'b0;
    if (w_count != '0) begin
      if (w_head.nobus) w_pop = SCT_allowin_w_i && !bus.inst_data_ok;
      else              w_pop = bus.inst_data_ok;
    end
  end

  // Next-state and accept. In REQ a new fetch can only be taken on the
  // cycle the current address handshakes, giving back-to-back issue.
  always_comb begin
    w_state_next = r_state;
    w_accept     = 1'b0;
    case (r_state)
      IDLE: begin
        w_accept = FCT_valid_i && w_free;
        if (w_accept && !FCT_hasException_i) w_state_next = REQ;
      end
      REQ: begin
        w_accept = FCT_valid_i && bus.inst_addr_ok &&
                   (((int'(w_count) + 1) < MAX_OUTSTANDING) || w_pop);
        if (bus.inst_addr_ok)
          w_state_next = (w_accept && !FCT_hasException_i) ? REQ : IDLE;
      end
      default: w_state_next = IDLE;
    endcase
  end

  assign w_accept_bus = w_accept && !FCT_hasException_i;
  assign w_bus_push   = w_in_req && bus.inst_addr_ok;
  assign w_exc_push   = w_accept && FCT_hasException_i;

  // A cancel seen at any point during the request, or on the handshake
  // cycle itself, condemns the response.
  always_comb begin
    w_bus_entry         = '0;
    w_bus_entry.nobus   = 1'b0;
    w_bus_entry.discard = r_cancel_seen || w_cancel;
    w_exc_entry         = '0;
    w_exc_entry.nobus   = 1'b1;
    w_exc_entry.discard = w_cancel;
  end

  // The handshaking bus entry is older than an exception accepted with it.
  assign w_push_a = w_bus_push || w_exc_push;
  assign w_data_a = w_bus_push ? w_bus_entry : w_exc_entry;
  assign w_push_b = w_bus_push && w_exc_push;

  fetch_track_fifo #(
    .DEPTH (MAX_OUTSTANDING),
    .CNT_W (CNT_W)
  ) u_track (
    .clk         (clk),
    .rst         (rst),
    .push_a      (w_push_a),
    .data_a      (w_data_a),
    .push_b      (w_push_b),
    .data_b      (w_exc_entry),
    .pop         (w_pop),
    .set_discard (w_cancel),
    .count       (w_count),
    .head        (w_head)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state       <= IDLE;
      r_inst_addr   <= '0;
      r_cancel_seen <= 1'b0;
      r_err         <= 1'b0;
    end else begin
      r_state <= w_state_next;
      if (w_accept_bus) begin
        r_inst_addr   <= FCT_PAddr_i;
        r_cancel_seen <= 1'b0;
      end else if (w_in_req && w_cancel) begin
        r_cancel_seen <= 1'b1;
      end
      if (bus.inst_data_ok && (w_count == '0)) r_err <= 1'b1;
    end
  end

  assign bus.inst_req  = w_in_req;
  assign bus.inst_wr   = 1'b0;
  assign bus.inst_size = c_INST_SIZE_WORD;
  assign bus.inst_addr = r_inst_addr;

  assign fetch_accept_o = w_accept;
  assign pipe_data_ok_o = w_pop && !w_head.discard && !w_cancel;
  assign pipe_exc_o     = pipe_data_ok_o && w_head.nobus;
  assign busy_o         = w_in_req || (w_count != '0);
  assign err_o          = r_err;

endmodule : inst_fetch_bus_ctrl
`default_nettype wire

// File: tb/tb_inst_fetch_bus_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_inst_fetch_bus_ctrl
//  Description : Directed self-checking bench for inst_fetch_bus_ctrl. The
//                bench plays the bus; each live completion it expects is
//                queued when the fetch is driven and checked when the DUT
//                reports it.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_inst_fetch_bus_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        valid;
  logic [31:0] paddr;
  logic        exc;
  logic        bsc;
  logic        cp0;
  logic        sba;
  logic        allowin;
  logic        fetch_accept_o;
  logic        pipe_data_ok_o;
  logic        pipe_exc_o;
  logic        busy_o;
  logic        err_o;

  int n_total = 0;
  int n_pass  = 0;
  int n_fail  = 0;

  // Expected live completions in order; value is the expected pipe_exc_o.
  logic sb[$];

  always #5 clk = ~clk;

  inst_fetch_bus_ctrl_if #(.ADDR_W(32)) bus_if ();

  inst_fetch_bus_ctrl #(
    .MAX_OUTSTANDING (2),
    .ADDR_W          (32)
  ) dut (
    .clk                (clk),
    .rst                (rst),
    .FCT_valid_i        (valid),
    .FCT_PAddr_i        (paddr),
    .FCT_hasException_i (exc),
    .BSC_needCancel_w_i (bsc),
    .CP0_excOccur_w_i   (cp0),
    .SBA_flush_w_i      (sba),
    .SCT_allowin_w_i    (allowin),
    .fetch_accept_o     (fetch_accept_o),
    .bus                (bus_if),
    .pipe_data_ok_o     (pipe_data_ok_o),
    .pipe_exc_o         (pipe_exc_o),
    .busy_o             (busy_o),
    .err_o              (err_o)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    valid = 1'b0; exc = 1'b0; bsc = 1'b0; cp0 = 1'b0; sba = 1'b0;
    allowin = 1'b1;
    bus_if.inst_addr_ok = 1'b0;
    bus_if.inst_data_ok = 1'b0;
  endtask

  // Scoreboard consumer: every completion must match the next expected one.
  always @(negedge clk) begin
    if (!rst && pipe_data_ok_o) begin
      if (sb.size() == 0) chk("sb_spurious_completion", 1, 0);
      else                chk("sb_exc_flag", pipe_exc_o, sb.pop_front());
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1;
    paddr = '0;
    idle_inputs();
    #2;
    chk("rst_inst_req",   bus_if.inst_req, 0);
    chk("rst_inst_addr",  bus_if.inst_addr, 0);
    chk("rst_busy",       busy_o, 0);
    chk("rst_err",        err_o, 0);
    chk("rst_pipe_ok",    pipe_data_ok_o, 0);
    chk("rst_pipe_exc",   pipe_exc_o, 0);
    chk("rst_accept",     fetch_accept_o, 0);
    chk("const_inst_wr",  bus_if.inst_wr, 0);
    chk("const_inst_size", bus_if.inst_size, 2'b10);
    @(negedge clk);
    rst = 1'b0;

    // ---- single fetch
    next_cycle(); valid = 1; paddr = 32'h1FC0_0000;
    sample(); chk("t1_accept", fetch_accept_o, 1); sb.push_back(1'b0);
    next_cycle(); valid = 0; paddr = '0;
    sample(); chk("t1_req_c1", bus_if.inst_req, 1); chk("t1_addr_c1", bus_if.inst_addr, 32'h1FC0_0000);
    next_cycle(); bus_if.inst_addr_ok = 1;
    sample(); chk("t1_req_c2", bus_if.inst_req, 1);
    next_cycle(); bus_if.inst_addr_ok = 0;
    sample(); chk("t1_req_c3", bus_if.inst_req, 0); chk("t1_busy_c3", busy_o, 1);
    next_cycle(); bus_if.inst_data_ok = 1;
    sample(); chk("t1_pipe_c4", pipe_data_ok_o, 1);
    next_cycle(); bus_if.inst_data_ok = 0;
    sample(); chk("t1_busy_c5", busy_o, 0);

    // ---- three back-to-back fetches, addr_ok always high
    next_cycle(); valid = 1; bus_if.inst_addr_ok = 1; paddr = 32'h0000_1000;
    sample(); chk("t2_acc0", fetch_accept_o, 1); sb.push_back(1'b0);
    next_cycle(); paddr = 32'h0000_1010;
    sample(); chk("t2_acc1", fetch_accept_o, 1); sb.push_back(1'b0);
    next_cycle(); paddr = 32'h0000_1020;
    sample(); chk("t2_stall_req", fetch_accept_o, 0);
    next_cycle();
    sample(); chk("t2_stall_full", fetch_accept_o, 0); chk("t2_req_low", bus_if.inst_req, 0);
    next_cycle(); bus_if.inst_data_ok = 1;
    sample(); chk("t2_stall_pop", fetch_accept_o, 0); chk("t2_pipe0", pipe_data_ok_o, 1);
    next_cycle(); bus_if.inst_data_ok = 0;
    sample(); chk("t2_acc2", fetch_accept_o, 1); sb.push_back(1'b0);
    next_cycle(); valid = 0;
    sample(); chk("t2_addr2", bus_if.inst_addr, 32'h0000_1020);
    next_cycle(); bus_if.inst_addr_ok = 0; bus_if.inst_data_ok = 1;
    sample(); chk("t2_pipe1", pipe_data_ok_o, 1);
    next_cycle();
    sample(); chk("t2_pipe2", pipe_data_ok_o, 1);
    next_cycle(); bus_if.inst_data_ok = 0;
    sample(); chk("t2_busy_end", busy_o, 0);

    // ---- cancel while two fetches outstanding, then a new fetch
    next_cycle(); valid = 1; bus_if.inst_addr_ok = 1; paddr = 32'h0000_2000;
    sample(); chk("t3_acc0", fetch_accept_o, 1);
    next_cycle(); paddr = 32'h0000_2010;
    sample(); chk("t3_acc1", fetch_accept_o, 1);
    next_cycle(); valid = 0;
    sample();
    next_cycle(); bus_if.inst_addr_ok = 0; bsc = 1;
    sample(); chk("t3_cancel_pipe", pipe_data_ok_o, 0); chk("t3_busy", busy_o, 1);
    next_cycle(); bsc = 0; bus_if.inst_data_ok = 1;
    sample(); chk("t3_drop0", pipe_data_ok_o, 0);
    next_cycle();
    sample(); chk("t3_drop1", pipe_data_ok_o, 0);
    next_cycle(); bus_if.inst_data_ok = 0; valid = 1; paddr = 32'h0000_2020;
    sample(); chk("t3_acc2", fetch_accept_o, 1); sb.push_back(1'b0);
    next_cycle(); valid = 0; bus_if.inst_addr_ok = 1;
    sample();
    next_cycle(); bus_if.inst_addr_ok = 0; bus_if.inst_data_ok = 1;
    sample(); chk("t3_live", pipe_data_ok_o, 1);
    next_cycle(); bus_if.inst_data_ok = 0;
    sample(); chk("t3_busy_end", busy_o, 0);

    // ---- cancel during REQ with addr_ok held low
    next_cycle(); valid = 1; paddr = 32'h0000_3000;
    sample(); chk("t4_accept", fetch_accept_o, 1);
    next_cycle(); valid = 0; cp0 = 1;
    sample(); chk("t4_req_a", bus_if.inst_req, 1); chk("t4_addr_a", bus_if.inst_addr, 32'h0000_3000);
    next_cycle(); cp0 = 0;
    sample(); chk("t4_req_b", bus_if.inst_req, 1); chk("t4_addr_b", bus_if.inst_addr, 32'h0000_3000);
    next_cycle();
    sample(); chk("t4_req_c", bus_if.inst_req, 1); chk("t4_addr_c", bus_if.inst_addr, 32'h0000_3000);
    next_cycle(); bus_if.inst_addr_ok = 1;
    sample(); chk("t4_req_hs", bus_if.inst_req, 1);
    next_cycle(); bus_if.inst_addr_ok = 0; bus_if.inst_data_ok = 1;
    sample(); chk("t4_suppressed", pipe_data_ok_o, 0);
    next_cycle(); bus_if.inst_data_ok = 0;
    sample(); chk("t4_busy_end", busy_o, 0);

    // ---- exception request with empty queue
    next_cycle(); valid = 1; exc = 1; paddr = 32'h0000_4000;
    sample(); chk("t5_exc_accept", fetch_accept_o, 1); sb.push_back(1'b1);
    next_cycle(); valid = 0; exc = 0;
    sample(); chk("t5_no_bus", bus_if.inst_req, 0); chk("t5_pipe", pipe_data_ok_o, 1);
    chk("t5_pipe_exc", pipe_exc_o, 1);
    next_cycle();
    sample(); chk("t5_busy_end", busy_o, 0);

    // ---- exception queued behind a bus fetch
    next_cycle(); valid = 1; paddr = 32'h0000_5000;
    sample(); chk("t6_acc_bus", fetch_accept_o, 1); sb.push_back(1'b0);
    next_cycle(); exc = 1; bus_if.inst_addr_ok = 1; paddr = 32'h0000_5010;
    sample(); chk("t6_acc_exc", fetch_accept_o, 1); sb.push_back(1'b1);
    next_cycle(); valid = 0; exc = 0; bus_if.inst_addr_ok = 0;
    sample(); chk("t6_wait_a", pipe_data_ok_o, 0); chk("t6_req_low", bus_if.inst_req, 0);
    next_cycle();
    sample(); chk("t6_wait_b", pipe_data_ok_o, 0);
    next_cycle(); bus_if.inst_data_ok = 1;
    sample(); chk("t6_bus_done", pipe_data_ok_o, 1); chk("t6_bus_exc", pipe_exc_o, 0);
    next_cycle(); bus_if.inst_data_ok = 0; allowin = 0;
    sample(); chk("t6_allowin_hold", pipe_data_ok_o, 0);
    next_cycle(); allowin = 1;
    sample(); chk("t6_exc_done", pipe_data_ok_o, 1); chk("t6_exc_flag", pipe_exc_o, 1);
    next_cycle();
    sample(); chk("t6_busy_end", busy_o, 0); chk("t6_addr_kept", bus_if.inst_addr, 32'h0000_5000);

    // ---- stray data_ok at idle sets sticky err
    next_cycle(); bus_if.inst_data_ok = 1;
    sample(); chk("t7_stray_pipe", pipe_data_ok_o, 0); chk("t7_err_pre", err_o, 0);
    next_cycle(); bus_if.inst_data_ok = 0;
    sample(); chk("t7_err_set", err_o, 1);
    next_cycle();
    sample(); chk("t7_err_sticky", err_o, 1);

    // ---- asynchronous reset in the middle of REQ
    next_cycle(); valid = 1; paddr = 32'h0000_6000;
    sample(); chk("t8_accept", fetch_accept_o, 1);
    next_cycle(); valid = 0;
    sample(); chk("t8_req_before", bus_if.inst_req, 1);
    #1 rst = 1'b1;
    #1;
    chk("t8_req_async", bus_if.inst_req, 0);
    chk("t8_busy_async", busy_o, 0);
    chk("t8_err_cleared", err_o, 0);
    chk("t8_addr_cleared", bus_if.inst_addr, 0);
    @(negedge clk);
    rst = 1'b0;

    // ---- cancel in the same cycle as the data return
    next_cycle(); valid = 1; paddr = 32'h0000_7000;
    sample(); chk("t9_accept", fetch_accept_o, 1);
    next_cycle(); valid = 0; bus_if.inst_addr_ok = 1;
    sample();
    next_cycle(); bus_if.inst_addr_ok = 0; bus_if.inst_data_ok = 1; sba = 1;
    sample(); chk("t9_same_cycle_cancel", pipe_data_ok_o, 0);
    next_cycle(); bus_if.inst_data_ok = 0; sba = 0;
    sample(); chk("t9_busy_end", busy_o, 0);

    next_cycle();
    chk("sb_drained", sb.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule : tb_inst_fetch_bus_ctrl
`default_nettype wire
